// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and helpers for the iterative integer divider.
//                div_op_t encodes the RV32M divide/remainder operations,
//                div_state_t the divider control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // Bit 0 of the op code distinguishes unsigned from signed forms.
    function automatic logic is_signed(input div_op_t op_in);
        return ~op_in[0];
    endfunction

    // Bit 1 of the op code selects the remainder instead of the quotient.
    function automatic logic is_rem(input div_op_t op_in);
        return op_in[1];
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One radix-2 restoring division step (purely combinational).
//                The {R,Q} pair is shifted left one place; the divisor
//                magnitude is trial-subtracted from R and the new quotient
//                bit is inserted in Q[0].
//  Ports       : i_rq          {R[WIDTH:0], Q[WIDTH-1:0]} before the step
//                i_divisor_mag unsigned divisor magnitude
//                o_rq          {R, Q} after the step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  i_rq,
    input  logic [WIDTH-1:0]  i_divisor_mag,
    output logic [2*WIDTH:0]  o_rq
);

    logic [2*WIDTH:0] w_shifted;
    logic [WIDTH:0]   w_trial;

    // R stays below the divisor between steps, so R[WIDTH] is always zero
    // and dropping it in the shift loses nothing.
    assign w_shifted = {i_rq[2*WIDTH-1:0], 1'b0};
    assign w_trial   = w_shifted[2*WIDTH:WIDTH] - {1'b0, i_divisor_mag};

    always_comb begin
        o_rq = w_shifted;
        if (!w_trial[WIDTH]) begin
            o_rq = {w_trial, w_shifted[WIDTH-1:1], 1'b1};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle iterative integer divider (DIV/DIVU/REM/REMU).
//                Operands are magnitude-converted on accept, WIDTH restoring
//                steps produce the unsigned quotient/remainder, and a final
//                fix-up cycle restores the signs. Divide-by-zero skips the
//                iteration entirely.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                flush             abort the in-flight operation
//                in_valid/in_ready operand handshake (ready == IDLE)
//                op, dividend,     operation and operands, sampled only on
//                divisor           the accept edge
//                out_valid/        result handshake
//                out_ready
//                result            quotient or remainder
//                busy              pipeline stall request (state != IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    div_state_t         r_state;
    div_state_t         w_state_next;
    div_op_t            r_op;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs_mag;
    logic [WIDTH-1:0]   r_result;
    logic [c_cnt_w-1:0] r_count;

    div_op_t            w_op;
    logic               w_accept;
    logic               w_div_zero;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [2*WIDTH:0]   w_step_out;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op       = div_op_t'(op);
    // flush wins over a simultaneous request in IDLE.
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_div_zero = (divisor == '0);
    assign w_dvd_neg  = is_signed(w_op) & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed(w_op) & divisor[WIDTH-1];

    // Two's-complement negate; the most negative value maps onto itself,
    // which is the correct unsigned magnitude 2^(WIDTH-1).
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;

    // Sign restoration; the wrap-around negate also yields the RV32M
    // overflow result (-2^(WIDTH-1) / -1) without a special case.
    assign w_quo_fix  = r_sign_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    div_step #(
        .WIDTH         (WIDTH)
    ) u_div_step (
        .i_rq          ({r_rem, r_quo}),
        .i_divisor_mag (r_dvs_mag),
        .o_rq          (w_step_out)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_next = w_div_zero ? DONE : ITER;
                    end
                end
                ITER: begin
                    // The step taken with count == 0 produces the last bit.
                    if (r_count == '0) begin
                        w_state_next = FIX;
                    end
                end
                FIX: begin
                    w_state_next = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= DIV;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs_mag <= '0;
            r_result  <= '0;
            r_count   <= '0;
        end else if (!flush) begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_op;
                        r_sign_q  <= w_dvd_neg ^ w_dvs_neg;
                        r_sign_r  <= w_dvd_neg;
                        r_rem     <= '0;
                        r_quo     <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_count   <= c_cnt_init;
                        // Divide-by-zero: quotient all ones, remainder is
                        // the untouched dividend for either signedness.
                        if (w_div_zero) begin
                            r_result <= is_rem(w_op) ? dividend : '1;
                        end
                    end
                end
                ITER: begin
                    {r_rem, r_quo} <= w_step_out;
                    r_count        <= r_count - c_cnt_one;
                end
                FIX: begin
                    r_result <= is_rem(r_op) ? w_rem_fix : w_quo_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

endmodule : seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle iterative integer divider for the execute stage. It implements DIV, DIVU, REM and REMU of RV32M. The ALU hands it operands over a valid/ready handshake, and it returns a single result over a second valid/ready handshake. It uses restoring radix-2 subtraction, producing one quotient bit per cycle. The pipeline stalls on `busy`.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the in-flight operation (branch mispredict/trap); synchronous
- in_valid  in  1  operands and op valid
- in_ready  out  1  divider can accept; equals (state == IDLE)
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  WIDTH  rs1 value
- divisor  in  WIDTH  rs2 value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  quotient or remainder per latched op
- busy  out  1  state != IDLE; pipeline stall request

Behaviour:
Reset and handshake:
- rst (sync, highest priority): state=IDLE, out_valid=0, result=0, all internal registers 0. in_ready=1 from the first cycle after reset.
- Accept when in_valid & in_ready on a rising edge. On accept, latch op and operands; in_ready drops the next cycle.

Operand preparation:
- Signed ops (DIV/REM): record sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
- Signed ops: take the magnitude of each operand as a WIDTH-bit two's-complement negate. |-2^(WIDTH-1)| = 2^(WIDTH-1) is held unsigned.
- Unsigned ops: sign_q = sign_r = 0.

FSM states: IDLE, ITER, FIX, DONE.
- IDLE -> ITER on accept with divisor != 0. Init: R = 0 (WIDTH+1 bits), Q = |dividend|, count = WIDTH-1.
- IDLE -> DONE on accept with divisor == 0. Shortcut: quotient = all ones; remainder = the original dividend, unsigned or signed alike.
- ITER, each cycle:
  - {R,Q} shift left by 1.
  - trial = R - {1'b0,|divisor|}, in WIDTH+1 bits.
  - If trial[MSB]==0, then R=trial and Q[0]=1; else Q[0]=0.
  - count decrements. When count==0 the cycle completes the last bit and the next state is FIX.
- FIX (one cycle):
  - Quotient = sign_q ? -Q : Q.
  - Remainder = sign_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - result is registered per op; then go to DONE.
- DONE: out_valid=1 and result stable. On out_valid & out_ready: go to IDLE and drop out_valid the next cycle. Hold indefinitely otherwise.

Latency and throughput:
- Normal: out_valid asserts WIDTH+2 cycles after the accept edge (34 for WIDTH=32).
- Divide-by-zero: out_valid asserts 1 cycle after the accept edge.
- Throughput: one op per (latency + 1) cycles minimum. No accept in the same cycle a result is consumed; in_ready rises the cycle after.

Boundary conditions:
- Signed overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1) and remainder = 0. This falls out of the wrap-around negate and needs no special case.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- flush in any state (rst excepted) -> IDLE next cycle, out_valid=0, no result emitted.
- flush together with in_valid in IDLE: the new operation is not accepted.
- rst mid-ITER or while in DONE: behaves as rst above; any pending result is discarded.
- Operand inputs are ignored outside the accept edge. Changing them mid-operation has no effect.

Decomposition:
- Package alu_pkg holds:
  - div_op_t enum: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
  - div_state_t enum: IDLE, ITER, FIX, DONE.
  - Helper function is_signed(op) and is_rem(op).
- One sub-module: div_step. It is combinational, takes {R,Q} and the divisor magnitude, and returns the next {R,Q}. It is unit-testable alone; the FSM, counter and handshakes stay in seq_divider.

Test Plan:
- DIVU 100/7, out_ready=1 -> result=14 with out_valid exactly 34 cycles after accept; REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF one cycle after accept; REM -5/0 -> 0xFFFFFFFB.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0 and busy=1 throughout; on release, in_ready=1 next cycle.
- Disturbances:
  - flush at ITER cycle 10 -> IDLE next cycle, no out_valid.
  - rst at ITER cycle 20 -> all outputs at reset values.
  - After each, a fresh DIVU 9/3 returns 3.
